keypad_entry_fsm: RTL and testbench
===================================

# keypad_entry_fsm

Consumes the one-cycle `strobe` and `{row,col}` `cur_key` produced by the keypad scanner and sequences calculator entry. Key presses are decoded into digits, operators, backspace, clear and equals. Two BCD operands are assembled and the completed `(op_a, op_code, op_b)` request is handed to the ALU over a valid/ready handshake. It sits between the keypad scanner and the arithmetic datapath, and also drives the display with the operand being edited.

## Interface
- DIGITS, 4: BCD digits per operand.
- TIMEOUT_CYCLES, 10_000_000: inactivity timeout in clk cycles; used only with KEYPAD_TIMEOUT_EN.
- clk  input  1  clock.
- nRst  input  1  reset, asynchronous, active-low.
- strobe  input  1  one-cycle key-press event from the scanner.
- cur_key  input  8  {row[3:0], col[3:0]}; row bit7 = row 0, col bit3 = col 0.
- req_ready  input  1  ALU accepts request.
- req_valid  output  1  request pending.
- op_a, op_b  output  4*DIGITS  BCD operands, most significant digit highest.
- op_code  output  2  0 = ADD, 1 = SUB, 2 = MUL.
- disp_bcd  output  4*DIGITS  operand currently being edited (op_a in ENTER_A, op_b in ENTER_B, op_b in ISSUE).
- state  output  2  current FSM state, for debug/LEDs.
- key_err  output  1  one-cycle pulse for a rejected strobe.

## Operation
- Key map by (row, col):
  - Row 0: 1 2 3 ADD.
  - Row 1: 4 5 6 SUB.
  - Row 2: 7 8 9 MUL.
  - Row 3: CLR(*) 0 EQ(#) BKSP.
- A strobe with zero bits or non-one-hot bits in either nibble of cur_key is invalid. It is ignored and pulses key_err.
- States: ENTER_A = 0, ENTER_B = 1, ISSUE = 2. Encoding 3 is unreachable and recovers to ENTER_A.
- Digit: operand <= {operand[4*DIGITS-5:0], d} and count += 1. If count == DIGITS, the digit is dropped silently with no error.
- BKSP: operand <= {4'd0, operand[4*DIGITS-1:4]} and count -= 1. No-op at count 0.
- Operator key in ENTER_A: latch op_code and go to ENTER_B. An empty A means A = 0.
- Operator key in ENTER_B:
  - count_b == 0: replaces op_code.
  - otherwise: ignored.
- EQ: in ENTER_B go to ISSUE. Ignored in ENTER_A.
- CLR: in ENTER_A/ENTER_B go to ENTER_A; op_a, op_b, counts and op_code are zeroed.
- ISSUE:
  - req_valid = 1; op_a, op_b and op_code are held stable until req_valid && req_ready.
  - Every strobe in ISSUE, including CLR, is rejected with key_err.
  - After the handshake: go to ENTER_A with all operands cleared.

## Timing
- Reset values:
  - state = ENTER_A; all operands, counts and op_code = 0.
  - req_valid = 0, key_err = 0, timeout counter = 0.
- A key action is sampled on the clk edge where strobe = 1. Its effect is visible on outputs the following cycle (1-cycle latency); key_err is registered with the same latency.
- req_valid rises the cycle after the EQ strobe.
- If req_ready is already high, the handshake completes in that first valid cycle. req_valid is low the next cycle.
- req_valid never drops without a handshake, except on reset.
- A reset asserted mid-operation, including in ISSUE, returns to reset values immediately; any pending request is lost.
- Strobes on consecutive cycles are each processed.

## Configuration
- KEYPAD_TIMEOUT_EN defined:
  - A counter runs in ENTER_A/ENTER_B and is cleared by every accepted or rejected strobe.
  - On reaching TIMEOUT_CYCLES-1, it performs CLR if any digit has been entered or the state is ENTER_B.
  - The counter is held at 0 in ISSUE.
- Not defined: no counter logic; entry persists indefinitely.

## Structure
- keypad_pkg holds:
  - key_t enum: KEY_0..KEY_9, KEY_ADD, KEY_SUB, KEY_MUL, KEY_BKSP, KEY_CLR, KEY_EQ, KEY_NONE.
  - op_t enum: OP_ADD, OP_SUB, OP_MUL.
  - state_t enum: ENTER_A, ENTER_B, ISSUE.
- Sub-module keypad_decoder: combinational, maps cur_key to key_t (KEY_NONE if invalid). Instantiated once.

## Test plan
- Reset, then keys 1,2,ADD,3,EQ with req_ready = 1 -> req_valid one cycle with op_a = 0x0012, op_b = 0x0003, op_code = 0; then state = ENTER_A with operands zero.
- Keys 9,8,7,6,5 -> op_a = 0x9876 (fifth digit dropped); then BKSP -> 0x0987; BKSP at count 0 -> no change.
- Complete an entry to ISSUE with req_ready = 0 for 5 cycles while pressing CLR and digit 4 -> req_valid and operands stable, key_err pulses twice; req_ready = 1 -> handshake, ENTER_A.
- ADD then SUB with B empty -> op_code = 1. Then digit 2 followed by MUL -> op_code stays 1.
- cur_key = 0x90 (two rows) or 0x00 with strobe -> key_err pulse, no state or operand change. Assert nRst in ISSUE -> all outputs return to reset values asynchronously.
- With KEYPAD_TIMEOUT_EN and TIMEOUT_CYCLES = 16: digit 5, then idle 16 cycles -> op_a = 0. No digits entered -> no clear action.

Source files
------------

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared types for the keypad calculator entry block: decoded
//               key codes, ALU operator codes, entry FSM states and the
//               helpers that map between them.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    // Digits occupy codes 0..9 so the low nibble of a digit key is its BCD value.
    typedef enum logic [4:0] {
        KEY_0    = 5'd0,
        KEY_1    = 5'd1,
        KEY_2    = 5'd2,
        KEY_3    = 5'd3,
        KEY_4    = 5'd4,
        KEY_5    = 5'd5,
        KEY_6    = 5'd6,
        KEY_7    = 5'd7,
        KEY_8    = 5'd8,
        KEY_9    = 5'd9,
        KEY_ADD  = 5'd10,
        KEY_SUB  = 5'd11,
        KEY_MUL  = 5'd12,
        KEY_BKSP = 5'd13,
        KEY_CLR  = 5'd14,
        KEY_EQ   = 5'd15,
        KEY_NONE = 5'd16
    } key_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2
    } op_t;

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        ISSUE   = 2'd2
    } state_t;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic op_t key_to_op(input key_t k);
        op_t o;
        case (k)
            KEY_SUB: o = OP_SUB;
            KEY_MUL: o = OP_MUL;
            default: o = OP_ADD;
        endcase
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_decoder.sv
`default_nettype none
// ============================================================================
// Module      : keypad_decoder
// Description : Combinational map from the scanner's one-hot {row,col} code
//               to a key_t. Any nibble that is not exactly one-hot yields
//               KEY_NONE.
// Ports       : cur_key [7:0] in  - {row[3:0], col[3:0]}, bit7 = row 0,
//                                   bit3 = col 0
//               key           out - decoded key
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_decoder
    import keypad_pkg::*;
(
    input  logic [7:0] cur_key,
    output key_t       key
);

    logic [1:0] row_idx;
    logic [1:0] col_idx;
    logic       valid;

    // Row 0 / col 0 sit in the most significant bit of each nibble.
    function automatic logic [1:0] nib_index(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b1000: idx = 2'd0;
            4'b0100: idx = 2'd1;
            4'b0010: idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    always_comb begin
        valid   = is_onehot4(cur_key[7:4]) && is_onehot4(cur_key[3:0]);
        row_idx = nib_index(cur_key[7:4]);
        col_idx = nib_index(cur_key[3:0]);
        key     = KEY_NONE;
        if (valid) begin
            case ({row_idx, col_idx})
                4'h0: key = KEY_1;
                4'h1: key = KEY_2;
                4'h2: key = KEY_3;
                4'h3: key = KEY_ADD;
                4'h4: key = KEY_4;
                4'h5: key = KEY_5;
                4'h6: key = KEY_6;
                4'h7: key = KEY_SUB;
                4'h8: key = KEY_7;
                4'h9: key = KEY_8;
                4'hA: key = KEY_9;
                4'hB: key = KEY_MUL;
                4'hC: key = KEY_CLR;
                4'hD: key = KEY_0;
                4'hE: key = KEY_EQ;
                default: key = KEY_BKSP;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/keypad_entry_fsm.sv
`default_nettype none
// ============================================================================
// Module      : keypad_entry_fsm
// Description : Calculator entry sequencer. Decodes scanner key strobes,
//               assembles two BCD operands and an operator, and hands the
//               request to the ALU over a valid/ready handshake.
// Options     : KEYPAD_TIMEOUT_EN - when defined, an inactivity counter
//               clears a partially entered calculation after TIMEOUT_CYCLES.
// Ports       : clk, nRst (async, active-low)
//               strobe, cur_key[7:0]  - key event from the scanner
//               req_ready / req_valid - ALU handshake
//               op_a, op_b, op_code   - request payload (BCD, MSD highest)
//               disp_bcd              - operand currently being edited
//               state                 - FSM state for debug
//               key_err               - one-cycle pulse on rejected strobe
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_entry_fsm
    import keypad_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int TIMEOUT_CYCLES = 10_000_000
) (
    input  logic                  clk,
    input  logic                  nRst,
    input  logic                  strobe,
    input  logic [7:0]            cur_key,
    input  logic                  req_ready,
    output logic                  req_valid,
    output logic [4*DIGITS-1:0]   op_a,
    output logic [4*DIGITS-1:0]   op_b,
    output logic [1:0]            op_code,
    output logic [4*DIGITS-1:0]   disp_bcd,
    output logic [1:0]            state,
    output logic                  key_err
);

    localparam int W     = 4 * DIGITS;
    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIGITS);

    key_t             key;
    state_t           state_q,   state_d;
    logic [W-1:0]     op_a_q,    op_a_d;
    logic [W-1:0]     op_b_q,    op_b_d;
    logic [CNT_W-1:0] cnt_a_q,   cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q,   cnt_b_d;
    op_t              op_code_q, op_code_d;
    logic             key_err_q, key_err_d;

    logic             edit_b;
    logic             do_clr;
    logic [W-1:0]     cur_op,  new_op;
    logic [CNT_W-1:0] cur_cnt, new_cnt;

`ifdef KEYPAD_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    logic [TMR_W-1:0] timer_q, timer_d;
`endif

    keypad_decoder u_decoder (
        .cur_key (cur_key),
        .key     (key)
    );

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q   <= ENTER_A;
            op_a_q    <= '0;
            op_b_q    <= '0;
            cnt_a_q   <= '0;
            cnt_b_q   <= '0;
            op_code_q <= OP_ADD;
            key_err_q <= 1'b0;
`ifdef KEYPAD_TIMEOUT_EN
            timer_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            cnt_a_q   <= cnt_a_d;
            cnt_b_q   <= cnt_b_d;
            op_code_q <= op_code_d;
            key_err_q <= key_err_d;
`ifdef KEYPAD_TIMEOUT_EN
            timer_q   <= timer_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        cnt_a_d   = cnt_a_q;
        cnt_b_d   = cnt_b_q;
        op_code_d = op_code_q;
        key_err_d = 1'b0;
        do_clr    = 1'b0;
`ifdef KEYPAD_TIMEOUT_EN
        timer_d   = timer_q;
`endif

        // Digit and backspace edits go through one shared path that operates
        // on whichever operand the current state is editing.
        edit_b  = (state_q == ENTER_B);
        cur_op  = edit_b ? op_b_q  : op_a_q;
        cur_cnt = edit_b ? cnt_b_q : cnt_a_q;
        new_op  = cur_op;
        new_cnt = cur_cnt;

        case (state_q)
            ENTER_A, ENTER_B: begin
                if (strobe) begin
                    if (key == KEY_NONE) begin
                        key_err_d = 1'b1;
                    end else if (key <= KEY_9) begin
                        // A full operand drops further digits without error.
                        if (cur_cnt != CNT_FULL) begin
                            new_op  = {cur_op[W-5:0], 4'(key)};
                            new_cnt = cur_cnt + 1'b1;
                        end
                    end else begin
                        case (key)
                            KEY_BKSP: begin
                                if (cur_cnt != '0) begin
                                    new_op  = {4'd0, cur_op[W-1:4]};
                                    new_cnt = cur_cnt - 1'b1;
                                end
                            end
                            KEY_ADD, KEY_SUB, KEY_MUL: begin
                                if (!edit_b) begin
                                    op_code_d = key_to_op(key);
                                    state_d   = ENTER_B;
                                end else if (cnt_b_q == '0) begin
                                    // Operator can still be changed until B has a digit.
                                    op_code_d = key_to_op(key);
                                end
                            end
                            KEY_EQ: begin
                                if (edit_b) begin
                                    state_d = ISSUE;
                                end
                            end
                            KEY_CLR: do_clr = 1'b1;
                            default: ;
                        endcase
                    end
                end
`ifdef KEYPAD_TIMEOUT_EN
                // Any strobe, accepted or rejected, counts as activity.
                if (strobe) begin
                    timer_d = '0;
                end else if (timer_q == TMR_LAST) begin
                    timer_d = '0;
                    if ((cnt_a_q != '0) || (cnt_b_q != '0) || edit_b) begin
                        do_clr = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
`endif
            end
            ISSUE: begin
                // The request payload is frozen here, so every key is refused.
                if (strobe) begin
                    key_err_d = 1'b1;
                end
                if (req_ready) begin
                    do_clr = 1'b1;
                end
`ifdef KEYPAD_TIMEOUT_EN
                timer_d = '0;
`endif
            end
            default: begin
                do_clr = 1'b1;
`ifdef KEYPAD_TIMEOUT_EN
                timer_d = '0;
`endif
            end
        endcase

        if (edit_b) begin
            op_b_d  = new_op;
            cnt_b_d = new_cnt;
        end else begin
            op_a_d  = new_op;
            cnt_a_d = new_cnt;
        end

        if (do_clr) begin
            state_d   = ENTER_A;
            op_a_d    = '0;
            op_b_d    = '0;
            cnt_a_d   = '0;
            cnt_b_d   = '0;
            op_code_d = OP_ADD;
        end
    end

    assign req_valid = (state_q == ISSUE);
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign op_code   = op_code_q;
    assign disp_bcd  = (state_q == ENTER_A) ? op_a_q : op_b_q;
    assign state     = state_q;
    assign key_err   = key_err_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_entry_fsm
// Description : Self-checking bench for keypad_entry_fsm. A queue-based model
//               of calculator entry is compared with the DUT every cycle;
//               directed sequences pin both DUT and model to literal values,
//               followed by a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_entry_fsm;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        nRst;
    logic        strobe;
    logic [7:0]  cur_key;
    logic        req_ready;
    logic        req_valid;
    logic [15:0] op_a, op_b, disp_bcd;
    logic [1:0]  op_code, state;
    logic        key_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Key legend by row*4+col: '+','-','*' operators, 'C' clear, '=' equals, '<' backspace.
    string KEYS = "123+456-789*C0=<";

    // Model state: entry mode (0 = A, 1 = B, 2 = issue), digit queues, operator, error pulse.
    int m_mode;
    int qa[$];
    int qb[$];
    int m_op;
    bit m_err;
    int m_idle;

    keypad_entry_fsm #(
        .DIGITS         (4),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .nRst      (nRst),
        .strobe    (strobe),
        .cur_key   (cur_key),
        .req_ready (req_ready),
        .req_valid (req_valid),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_code   (op_code),
        .disp_bcd  (disp_bcd),
        .state     (state),
        .key_err   (key_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pack(input int q[$]);
        logic [15:0] v = 16'h0;
        foreach (q[i]) v = (v << 4) | 16'(q[i]);
        return v;
    endfunction

    function automatic void model_reset();
        m_mode = 0; qa = {}; qb = {}; m_op = 0; m_err = 0; m_idle = 0;
    endfunction

    function automatic void model_clear();
        m_mode = 0; qa = {}; qb = {}; m_op = 0;
    endfunction

    // Returns key index 0..15, or -1 when either nibble is not one-hot.
    function automatic int key_index(input logic [7:0] k);
        int r = -1;
        int c = -1;
        if ($countones(k[7:4]) != 1 || $countones(k[3:0]) != 1) return -1;
        for (int i = 0; i < 4; i++) begin
            if (k[7-i]) r = i;
            if (k[3-i]) c = i;
        end
        return r * 4 + c;
    endfunction

    function automatic void model_key(input byte ch);
        if (ch >= "0" && ch <= "9") begin
            if (m_mode == 0) begin
                if (qa.size() < 4) qa.push_back(ch - "0");
            end else begin
                if (qb.size() < 4) qb.push_back(ch - "0");
            end
        end else if (ch == "<") begin
            if (m_mode == 0) begin
                if (qa.size() > 0) void'(qa.pop_back());
            end else begin
                if (qb.size() > 0) void'(qb.pop_back());
            end
        end else if (ch == "+" || ch == "-" || ch == "*") begin
            int o = (ch == "+") ? 0 : (ch == "-") ? 1 : 2;
            if (m_mode == 0) begin
                m_op = o; m_mode = 1;
            end else if (qb.size() == 0) begin
                m_op = o;
            end
        end else if (ch == "=") begin
            if (m_mode == 1) m_mode = 2;
        end else if (ch == "C") begin
            model_clear();
        end
    endfunction

    // Advances the model across one rising edge with the given inputs.
    function automatic void model_step(input logic s, input logic [7:0] k, input logic rdy);
        m_err = 0;
        if (m_mode == 2) begin
            m_idle = 0;
            if (s) m_err = 1;
            if (rdy) model_clear();
        end else if (s) begin
            int idx = key_index(k);
            m_idle = 0;
            if (idx < 0) m_err = 1;
            else model_key(KEYS[idx]);
        end else begin
`ifdef KEYPAD_TIMEOUT_EN
            if (m_idle == TMO - 1) begin
                m_idle = 0;
                if (qa.size() > 0 || qb.size() > 0 || m_mode == 1) model_clear();
            end else begin
                m_idle++;
            end
`endif
        end
    endfunction

    // Compare process: outputs at each falling edge, then advance the model
    // with the inputs that the next rising edge will sample.
    initial begin
        forever begin
            @(negedge clk);
            if (!nRst) model_reset();
            chk("state",     {14'd0, state},     16'(m_mode));
            chk("req_valid", {15'd0, req_valid}, {15'd0, (m_mode == 2)});
            chk("op_a",      op_a,               pack(qa));
            chk("op_b",      op_b,               pack(qb));
            chk("op_code",   {14'd0, op_code},   16'(m_op));
            chk("disp_bcd",  disp_bcd,           (m_mode == 0) ? pack(qa) : pack(qb));
            chk("key_err",   {15'd0, key_err},   {15'd0, m_err});
            if (nRst) model_step(strobe, cur_key, req_ready);
        end
    end

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    task automatic press_raw(input logic [7:0] k);
        strobe  = 1'b1;
        cur_key = k;
        sync();
        strobe  = 1'b0;
        cur_key = 8'h00;
    endtask

    task automatic press(input byte ch);
        logic [3:0] rv, cv;
        for (int i = 0; i < 16; i++) begin
            if (KEYS[i] == ch) begin
                rv = 4'b1000 >> (i / 4);
                cv = 4'b1000 >> (i % 4);
            end
        end
        press_raw({rv, cv});
    endtask

    task automatic idle(input int n);
        repeat (n) sync();
    endtask

    initial begin
        nRst = 1'b0; strobe = 1'b0; cur_key = 8'h00; req_ready = 1'b0;
        model_reset();
        idle(2);
        chk("reset_state", {14'd0, state}, 16'd0);
        chk("reset_valid", {15'd0, req_valid}, 16'd0);
        chk("reset_op_a",  op_a, 16'h0000);
        nRst = 1'b1;
        sync();

        // 12 + 3 with the ALU already ready.
        req_ready = 1'b1;
        press("1"); press("2"); press("+"); press("3"); press("=");
        chk("t1_valid",   {15'd0, req_valid}, 16'd1);
        chk("t1_op_a",    op_a, 16'h0012);
        chk("t1_op_b",    op_b, 16'h0003);
        chk("t1_op_code", {14'd0, op_code}, 16'd0);
        chk("t1_model_a", pack(qa), 16'h0012);
        sync();
        chk("t1_post_valid", {15'd0, req_valid}, 16'd0);
        chk("t1_post_state", {14'd0, state}, 16'd0);
        chk("t1_post_op_a",  op_a, 16'h0000);
        req_ready = 1'b0;

        // Overflow digit dropped, backspace, backspace at empty.
        press("9"); press("8"); press("7"); press("6"); press("5");
        chk("t2_full",    op_a, 16'h9876);
        chk("t2_model",   pack(qa), 16'h9876);
        chk("t2_no_err",  {15'd0, key_err}, 16'd0);
        press("<");
        chk("t2_bksp",    op_a, 16'h0987);
        press("<"); press("<"); press("<");
        chk("t2_empty",   op_a, 16'h0000);
        press("<");
        chk("t2_bksp0",   op_a, 16'h0000);
        press("1");
        chk("t2_after0",  op_a, 16'h0001);
        press("C");

        // Held request with keys rejected.
        press("4"); press("+"); press("5"); press("=");
        press("C");
        chk("t3_err_clr", {15'd0, key_err}, 16'd1);
        press("4");
        chk("t3_err_dig", {15'd0, key_err}, 16'd1);
        idle(3);
        chk("t3_err_low", {15'd0, key_err}, 16'd0);
        chk("t3_valid",   {15'd0, req_valid}, 16'd1);
        chk("t3_op_a",    op_a, 16'h0004);
        chk("t3_op_b",    op_b, 16'h0005);
        chk("t3_disp",    disp_bcd, 16'h0005);
        req_ready = 1'b1;
        sync();
        req_ready = 1'b0;
        chk("t3_done",    {14'd0, state}, 16'd0);

        // Operator replacement only while B is empty.
        press("+"); press("-");
        chk("t4_sub",     {14'd0, op_code}, 16'd1);
        chk("t4_state",   {14'd0, state}, 16'd1);
        press("2"); press("*");
        chk("t4_keep",    {14'd0, op_code}, 16'd1);
        chk("t4_disp",    disp_bcd, 16'h0002);
        press("C");

        // Invalid key codes.
        press("7");
        press_raw(8'h90);
        chk("t5_err_90",  {15'd0, key_err}, 16'd1);
        chk("t5_op_a",    op_a, 16'h0007);
        press_raw(8'h00);
        chk("t5_err_00",  {15'd0, key_err}, 16'd1);
        chk("t5_state",   {14'd0, state}, 16'd0);

        // Asynchronous reset while a request is pending.
        press("+"); press("8"); press("=");
        chk("t6_valid",   {15'd0, req_valid}, 16'd1);
        nRst = 1'b0;
        #1;
        chk("t6_rst_valid", {15'd0, req_valid}, 16'd0);
        chk("t6_rst_state", {14'd0, state}, 16'd0);
        chk("t6_rst_op_a",  op_a, 16'h0000);
        chk("t6_rst_op_b",  op_b, 16'h0000);
        sync();
        nRst = 1'b1;
        sync();

        // Inactivity behaviour.
        press("5");
        idle(TMO - 1);
        chk("t7_before",  op_a, 16'h0005);
        idle(1);
`ifdef KEYPAD_TIMEOUT_EN
        chk("t7_timeout", op_a, 16'h0000);
        idle(2 * TMO);
        chk("t7_idle_st", {14'd0, state}, 16'd0);
`else
        chk("t7_persist", op_a, 16'h0005);
        idle(2 * TMO);
        chk("t7_persist2", op_a, 16'h0005);
`endif
        press("C");

        // Randomized phase, checked every cycle by the compare process.
        for (int i = 0; i < 3000; i++) begin
            req_ready = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 299) == 0) begin
                nRst = 1'b0;
                sync();
                nRst = 1'b1;
                sync();
            end else if ($urandom_range(0, 1) == 0) begin
                if ($urandom_range(0, 9) == 0) press_raw(8'($urandom));
                else press(KEYS[$urandom_range(0, 15)]);
            end else begin
                sync();
            end
        end
        req_ready = 1'b0;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
